// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared CPU constants for the register write-back path: index/data widths,
// write-back FSM encoding and the buffered request record.
package reg_writeback_ctrl_pkg;

  localparam int IDX_W  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// Write-request FIFO: wrap-bit pointers, combinational head and a
// destination-match lookup over all occupied entries for hazard detection.
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy,
  input  logic [IDX_W-1:0] qa,
  input  logic [IDX_W-1:0] qb,
  output logic             match_a,
  output logic             match_b
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wp, rp, diff;
  logic [AW-1:0] idx;
  wb_entry_t     mem [DEPTH];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // storage is data only; validity comes from the pointers
  always_ff @(posedge clock) begin
    if (push) mem[wp[AW-1:0]] <= push_entry;
  end

  assign diff      = wp - rp;
  assign occupancy = CNT_W'(diff);
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head      = mem[rp[AW-1:0]];

  // walk from the read pointer so only live entries take part in the match
  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp[AW-1:0] + AW'(k);
      if ((AW+1)'(k) < diff) begin
        if (mem[idx].dest == qa) match_a = 1'b1;
        if (mem[idx].dest == qb) match_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register write-back controller: buffers write requests and replays them to
// the register bank as setup / strobe / release cycles with a registered strobe.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [IDX_W-1:0]  wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              load,
  output logic [IDX_W-1:0]  des1,
  output logic [DATA_W-1:0] w1,
  input  logic [IDX_W-1:0]  qa,
  input  logic [IDX_W-1:0]  qb,
  output logic              busy_a,
  output logic              busy_b,
  output logic [CNT_W-1:0]  count,
  output logic              idle
);

  wb_state_e        state, state_n;
  wb_entry_t        head, in_entry;
  logic             push, pop, full, empty;
  logic             ready_q, inflight, match_a, match_b;
  logic [CNT_W-1:0] occ;

  // r0 is hard-wired zero: such requests are acknowledged but never queued
  assign wb_ready = ready_q & ~full;
  assign push     = wb_valid & wb_ready & (wb_dest != '0);
  assign in_entry = {wb_dest, wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .rst        (rst),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .occupancy  (occ),
    .qa         (qa),
    .qb         (qb),
    .match_a    (match_a),
    .match_b    (match_b)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_n = ST_SETUP;
          pop     = 1'b1;
        end
      end
      ST_SETUP:  state_n = ST_STROBE;
      ST_STROBE: state_n = ST_RELEASE;
      ST_RELEASE: begin
        if (!empty) begin
          state_n = ST_SETUP;
          pop     = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // strobe comes from its own flop so the bank never sees a decode glitch
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      load    <= 1'b0;
      des1    <= '0;
      w1      <= '0;
    end else begin
      ready_q <= 1'b1;
      load    <= (state_n == ST_STROBE);
      if (pop) begin
        des1 <= head.dest;
        w1   <= head.data;
      end
    end
  end

  assign inflight = (state != ST_IDLE);
  assign count    = occ + CNT_W'(inflight);
  assign idle     = (count == '0) && (state == ST_IDLE);
  assign busy_a   = (qa != '0) && (match_a || (inflight && (des1 == qa)));
  assign busy_b   = (qb != '0) && (match_b || (inflight && (des1 == qb)));

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: bank model on the load rising edge,
// in-order expectation queue, and hand-computed checks per step.
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              rst = 1'b0;
  logic              wb_valid = 1'b0;
  logic              wb_ready;
  logic [IDX_W-1:0]  wb_dest = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              load;
  logic [IDX_W-1:0]  des1;
  logic [DATA_W-1:0] w1;
  logic [IDX_W-1:0]  qa = '0;
  logic [IDX_W-1:0]  qb = '0;
  logic              busy_a, busy_b;
  logic [CNT_W-1:0]  count;
  logic              idle;

  int tests = 0;
  int fails = 0;
  int load_edges = 0;
  int edges0;
  int base;
  logic [31:0] bank     [16];
  logic [31:0] ref_bank [16];
  wb_entry_t   exp_q [$];
  wb_entry_t   mon_e;
  longint      load_t [$];

  reg_writeback_ctrl #(.DEPTH(4)) dut (
    .clock    (clock),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_dest  (wb_dest),
    .wb_data  (wb_data),
    .load     (load),
    .des1     (des1),
    .w1       (w1),
    .qa       (qa),
    .qb       (qb),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .count    (count),
    .idle     (idle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // leaves wb_valid high so consecutive calls push back-to-back
  task automatic push_req(input logic [3:0] d, input logic [31:0] v);
    int n;
    n = 0;
    wb_valid = 1'b1;
    wb_dest  = d;
    wb_data  = v;
    while (!wb_ready && n < 100) begin
      step();
      n++;
    end
    chk("push_ready", {31'd0, wb_ready}, 32'd1);
    step();
    if (d != 4'd0) exp_q.push_back(wb_entry_t'({d, v}));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle && n < 200) begin
      step();
      n++;
    end
    chk("idle_reached", {31'd0, idle}, 32'd1);
  endtask

  // the bank captures on the strobe's rising edge; each one must match the next queued request
  always @(posedge load) begin
    chk("load_expected", {31'd0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("load_dest", {28'd0, des1}, {28'd0, mon_e.dest});
      chk("load_data", w1, mon_e.data);
    end
    bank[des1] = w1;
    load_edges++;
    load_t.push_back(longint'($time));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 32'd0;
    qa = 4'd5;
    qb = 4'd9;
    wb_valid = 1'b1;
    wb_dest  = 4'd5;
    wb_data  = 32'h1234;
    repeat (2) step();

    // reset state
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_load",     {31'd0, load},     32'd0);
    chk("rst_des1",     {28'd0, des1},     32'd0);
    chk("rst_w1",       w1,                32'd0);
    chk("rst_count",    {27'd0, count},    32'd0);
    chk("rst_idle",     {31'd0, idle},     32'd1);
    chk("rst_busy_a",   {31'd0, busy_a},   32'd0);
    chk("rst_busy_b",   {31'd0, busy_b},   32'd0);
    wb_valid = 1'b0;
    rst = 1'b1;
    chk("ready_before_edge", {31'd0, wb_ready}, 32'd0);
    step();
    chk("ready_after_edge", {31'd0, wb_ready}, 32'd1);

    // single write: accept edge, then SETUP, then STROBE raises load
    edges0 = load_edges;
    push_req(4'd5, 32'hDEADBEEF);
    wb_valid = 1'b0;
    chk("single_count_acc", {27'd0, count}, 32'd1);
    chk("single_load_acc",  {31'd0, load},  32'd0);
    step();
    chk("single_load_setup", {31'd0, load}, 32'd0);
    chk("single_des1",       {28'd0, des1}, 32'd5);
    chk("single_w1",         w1,            32'hDEADBEEF);
    step();
    chk("single_load_strobe", {31'd0, load}, 32'd1);
    step();
    chk("single_load_release", {31'd0, load},  32'd0);
    chk("single_count_rel",    {27'd0, count}, 32'd1);
    chk("single_des1_held",    {28'd0, des1},  32'd5);
    step();
    chk("single_count_end", {27'd0, count}, 32'd0);
    chk("single_idle_end",  {31'd0, idle},  32'd1);
    chk("single_bank_r5",   bank[5],        32'hDEADBEEF);
    chk("single_edges",     load_edges - edges0, 32'd1);

    // write to r0 is acknowledged and dropped
    edges0 = load_edges;
    wb_valid = 1'b1;
    wb_dest  = 4'd0;
    wb_data  = 32'hFFFFFFFF;
    chk("r0_ready", {31'd0, wb_ready}, 32'd1);
    step();
    wb_valid = 1'b0;
    chk("r0_count_acc", {27'd0, count}, 32'd0);
    repeat (5) step();
    chk("r0_count", {27'd0, count}, 32'd0);
    chk("r0_edges", load_edges - edges0, 32'd0);
    chk("r0_bank",  bank[0], 32'd0);

    // hazard on qa=7 from accept through RELEASE, qb=3 never busy
    qa = 4'd7;
    qb = 4'd3;
    chk("haz_busy_a_pre", {31'd0, busy_a}, 32'd0);
    push_req(4'd7, 32'h77);
    wb_valid = 1'b0;
    chk("haz_busy_a_acc", {31'd0, busy_a}, 32'd1);
    chk("haz_busy_b_acc", {31'd0, busy_b}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("haz_busy_a_fly", {31'd0, busy_a}, 32'd1);
      chk("haz_busy_b_fly", {31'd0, busy_b}, 32'd0);
    end
    step();
    chk("haz_busy_a_done", {31'd0, busy_a}, 32'd0);
    chk("haz_des1_kept",   {28'd0, des1},   32'd7);

    // burst of six into a four-deep FIFO
    edges0 = load_edges;
    for (int i = 0; i < 6; i++) push_req(4'(i + 1), 32'h10 + 32'(i));
    wb_valid = 1'b0;
    chk("burst_full_ready", {31'd0, wb_ready}, 32'd0);
    chk("burst_count_full", {27'd0, count},    32'd5);
    wait_idle();
    chk("burst_count_end", {27'd0, count}, 32'd0);
    chk("burst_edges",     load_edges - edges0, 32'd6);
    chk("burst_exp_left",  exp_q.size(), 32'd0);
    base = load_t.size() - 6;
    for (int i = 1; i < 6; i++)
      chk("burst_spacing", 32'(load_t[base + i] - load_t[base + i - 1]), 32'd30);
    for (int i = 1; i <= 6; i++)
      chk("burst_bank", bank[i], 32'h10 + 32'(i - 1));

    // reset while strobing with two entries still queued
    push_req(4'd8,  32'hA8);
    push_req(4'd9,  32'hA9);
    push_req(4'd10, 32'hAA);
    wb_valid = 1'b0;
    chk("rststb_load",  {31'd0, load},  32'd1);
    chk("rststb_count", {27'd0, count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rststb_load_drop", {31'd0, load},     32'd0);
    chk("rststb_count0",    {27'd0, count},    32'd0);
    chk("rststb_idle",      {31'd0, idle},     32'd1);
    chk("rststb_ready",     {31'd0, wb_ready}, 32'd0);
    exp_q.delete();
    edges0 = load_edges;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rststb_ready_back", {31'd0, wb_ready}, 32'd1);
    repeat (10) step();
    chk("rststb_no_loads", load_edges - edges0, 32'd0);
    chk("rststb_r9_kept",  bank[9],             32'h0);

    // twenty back-to-back pushes wrap the pointers several times
    for (int i = 0; i < 16; i++) ref_bank[i] = bank[i];
    edges0 = load_edges;
    for (int i = 0; i < 20; i++) begin
      logic [3:0]  d;
      logic [31:0] v;
      d = 4'($urandom_range(15, 1));
      v = $urandom;
      ref_bank[d] = v;
      push_req(d, v);
    end
    wb_valid = 1'b0;
    wait_idle();
    chk("wrap_edges",    load_edges - edges0, 32'd20);
    chk("wrap_exp_left", exp_q.size(),        32'd0);
    chk("wrap_r0",       bank[0],             32'd0);
    for (int i = 1; i < 16; i++) chk("wrap_bank", bank[i], ref_bank[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
